// File: rtl/merge_n_ctrl.sv
// merge_n_ctrl: N-way valid/ready merge into one registered output slot.
// MODE=0 takes inputs in queued control-token order, MODE=1 round-robins.
module merge_n_ctrl #(
    parameter int WIDTH      = 8,
    parameter int NUM_IN     = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_IN),
    parameter int MODE       = 0,
    parameter int CTRL_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ctrl_valid,
    output logic                    ctrl_ready,
    input  logic [SEL_WIDTH-1:0]    ctrl_sel,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]    out_src,
    output logic                    err_sel
);
    localparam int PW = $clog2(CTRL_DEPTH);
    localparam logic [SEL_WIDTH:0] N_SEL = (SEL_WIDTH + 1)'(NUM_IN);
    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NUM_IN - 1);
    localparam bit CTRL_MODE = (MODE == 0);

    logic [SEL_WIDTH-1:0] fifo_q [CTRL_DEPTH];
    logic [SEL_WIDTH-1:0] fifo_d [CTRL_DEPTH];
    logic [PW:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]          rd_ptr_q, rd_ptr_d;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic [SEL_WIDTH-1:0] head;
    logic                 head_ok;

    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_WIDTH-1:0] rr_grant;
    logic                 rr_found;
    logic [SEL_WIDTH:0]   rr_sum;
    logic [SEL_WIDTH-1:0] rr_idx;

    logic [SEL_WIDTH-1:0] sel;
    logic                 sel_act;
    logic [WIDTH-1:0]     sel_data;
    logic                 slot_free;
    logic                 take;

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0] out_src_q, out_src_d;

    // Extra pointer bit separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];
    assign head_ok    = ({1'b0, head} < N_SEL);
    assign ctrl_ready = CTRL_MODE && !fifo_full;
    assign push       = ctrl_valid && ctrl_ready;

    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (SEL_WIDTH + 1)'(i);
            if (rr_sum >= N_SEL) begin
                rr_sum = rr_sum - N_SEL;
            end
            rr_idx = rr_sum[SEL_WIDTH-1:0];
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    always_comb begin
        if (CTRL_MODE) begin
            sel     = head;
            sel_act = !fifo_empty && head_ok;
        end else begin
            sel     = rr_grant;
            sel_act = rr_found;
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign take      = sel_act && slot_free && in_valid[sel];
    assign err_sel   = CTRL_MODE && !fifo_empty && !head_ok;
    assign pop       = CTRL_MODE && !fifo_empty && (take || !head_ok);

    always_comb begin
        in_ready = '0;
        if (sel_act && slot_free) begin
            in_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q[PW-1:0]] = ctrl_sel;
            wr_ptr_d = wr_ptr_q + (PW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW + 1)'(1);
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!CTRL_MODE && take) begin
            rr_ptr_d = (sel == LAST) ? '0 : sel + SEL_WIDTH'(1);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CTRL_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
endmodule
